// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath run/step controller and anything that observes it.
package datapath_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } run_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;
  localparam int unsigned RETIRED_W          = 16;

endpackage

// File: rtl/key_debounce.sv
// Conditions an asynchronous active-low push-button into a one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; idles at released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accepted level moves only after a full run of disagreeing samples; a 1->0 move is a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/datapath_run_controller.sv
// Run/step sequencer: issues a registered one-cycle cpu_en that gates every datapath state update.
module datapath_run_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RUN_DIV         = 1,
  parameter int unsigned ADDR_W          = 16,
  parameter logic [31:0] HALT_INSTR      = HALT_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_key_n,
  input  logic                 run_sw,
  input  logic                 bp_en,
  input  logic [ADDR_W-1:0]    bp_addr,
  input  logic [31:0]          pc,
  input  logic [31:0]          instr,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 halted,
  output logic [RETIRED_W-1:0] retired
);

  localparam int unsigned EFF_DIV = (RUN_DIV == 0) ? 1 : RUN_DIV;
  localparam int unsigned DIV_W   = (EFF_DIV > 1) ? $clog2(EFF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(EFF_DIV - 1);
  localparam logic [RETIRED_W-1:0] RETIRED_MAX = '1;

  run_state_t       cur_state;
  run_state_t       nxt_state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             cpu_en_nxt;
  logic             press;
  logic             halt_cond;
  logic             bp_hit;
  logic             div_term;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .reset(reset),
    .key_n(step_key_n),
    .press(press)
  );

  // Only the low ADDR_W pc bits take part in the breakpoint compare.
  if (ADDR_W < 32) begin : g_pc_unused
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[31:ADDR_W];
  end

  assign halt_cond = (instr == HALT_INSTR);
  assign bp_hit    = bp_en && (pc[ADDR_W-1:0] == bp_addr);
  assign div_term  = (div_cnt == DIV_LAST);
  assign state     = cur_state;

  always_comb begin
    nxt_state  = cur_state;
    cpu_en_nxt = 1'b0;
    div_nxt    = '0;
    case (cur_state)
      ST_IDLE: begin
        if (run_sw) begin
          nxt_state = ST_RUN;
        end else if (press) begin
          if (halt_cond) begin
            nxt_state = ST_HALT;
          end else begin
            nxt_state  = ST_STEP;
            cpu_en_nxt = 1'b1;
          end
        end
      end
      ST_STEP: nxt_state = ST_IDLE;
      ST_RUN: begin
        // Leaving RUN wins over a terminal count, so no issue escapes on the way out.
        if (!run_sw) begin
          nxt_state = ST_IDLE;
        end else begin
          div_nxt = div_term ? '0 : div_cnt + DIV_W'(1);
          if (div_term) begin
            if (halt_cond || bp_hit) begin
              nxt_state = ST_HALT;
            end else begin
              cpu_en_nxt = 1'b1;
            end
          end
        end
      end
      ST_HALT: begin
        if (press && !run_sw) begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      div_cnt   <= '0;
      cpu_en    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      div_cnt   <= div_nxt;
      cpu_en    <= cpu_en_nxt;
      halted    <= (nxt_state == ST_HALT);
    end
  end

  // Retired-instruction count, pinned at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (cpu_en && (retired != RETIRED_MAX)) begin
      retired <= retired + RETIRED_W'(1);
    end
  end

endmodule
